// File: rtl/secuenciador_muestreo_if.sv
// Handshake and status bundle between the sample scheduler and its controller.
interface secuenciador_muestreo_if;
  logic        run;
  logic        clr_flags;
  logic [1:0]  filtro_req;
  logic        adc_done;
  logic        dac_done;
  logic        adc_start;
  logic        sample_load;
  logic        filt_enable;
  logic        dac_start;
  logic [1:0]  filtro_sel;
  logic        busy;
  logic        overrun;
  logic        timeout;
  logic [15:0] sample_count;

  modport master (
    output run, clr_flags, filtro_req, adc_done, dac_done,
    input  adc_start, sample_load, filt_enable, dac_start, filtro_sel,
           busy, overrun, timeout, sample_count
  );

  modport slave (
    input  run, clr_flags, filtro_req, adc_done, dac_done,
    output adc_start, sample_load, filt_enable, dac_start, filtro_sel,
           busy, overrun, timeout, sample_count
  );
endinterface

// File: rtl/secuenciador_muestreo.sv
// Per-sample scheduler: sample tick, ADC start, sample load, filter window, DAC start.
// Optional wait-state timeout enabled by defining SEQ_TIMEOUT_EN.
module secuenciador_muestreo #(
  parameter int unsigned CLK_DIV     = 2268,
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                   clock_In,
  input  logic                   Reset,
  secuenciador_muestreo_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned FLT_W = $clog2(FILT_CYCLES + 1);

  if (CLK_DIV < 8 || FILT_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
    $error("secuenciador_muestreo: illegal parameter values");
  end

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADC_WAIT = 3'd1,
    LOAD     = 3'd2,
    FILTER   = 3'd3,
    DAC_WAIT = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FLT_W-1:0]  filt_cnt_q, filt_cnt_d;
  logic              adc_prev_q, dac_prev_q;
  logic              adc_start_q, adc_start_d;
  logic              sample_load_q, sample_load_d;
  logic              filt_enable_q, filt_enable_d;
  logic              dac_start_q, dac_start_d;
  logic [1:0]        filtro_sel_q, filtro_sel_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       sample_count_q, sample_count_d;
  logic              tick_c, adc_edge_c, dac_edge_c, wait_expired_c;

  // Sample-rate counter; held at zero while sampling is disabled
  always_comb begin
    tick_c = bus.run && (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d  = '0;
    if (bus.run && !tick_c) cnt_d = cnt_q + CNT_W'(1);
    adc_edge_c = bus.adc_done && !adc_prev_q;
    dac_edge_c = bus.dac_done && !dac_prev_q;
  end

  // Sequencer next state; outputs are decoded from the next state so they register in step with it
  always_comb begin
    state_d        = state_q;
    filt_cnt_d     = filt_cnt_q;
    filtro_sel_d   = filtro_sel_q;
    sample_count_d = sample_count_q;
    case (state_q)
      IDLE:     if (tick_c) state_d = ADC_WAIT;
      ADC_WAIT: begin
        if (adc_edge_c) begin
          state_d      = LOAD;
          filtro_sel_d = bus.filtro_req;
        end else if (wait_expired_c) begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d    = FILTER;
        filt_cnt_d = '0;
      end
      FILTER: begin
        if (filt_cnt_q == FLT_W'(FILT_CYCLES - 1)) state_d = DAC_WAIT;
        else                                       filt_cnt_d = filt_cnt_q + FLT_W'(1);
      end
      DAC_WAIT: begin
        if (dac_edge_c) begin
          state_d        = IDLE;
          sample_count_d = sample_count_q + 16'd1;
        end else if (wait_expired_c) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase

    adc_start_d   = (state_q == IDLE) && (state_d == ADC_WAIT);
    sample_load_d = (state_d == LOAD);
    filt_enable_d = (state_d == FILTER);
    dac_start_d   = (state_q == FILTER) && (state_d == DAC_WAIT);
    busy_d        = (state_d != IDLE);
    // A set event beats a simultaneous clear
    overrun_d     = (tick_c && state_q != IDLE) ? 1'b1 : (bus.clr_flags ? 1'b0 : overrun_q);
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic             in_wait_c, leave_c;

  // Wait-state watchdog; a done edge in the last allowed cycle still wins
  always_comb begin
    in_wait_c      = (state_q == ADC_WAIT) || (state_q == DAC_WAIT);
    wait_expired_c = in_wait_c && (wait_cnt_q == TMO_W'(TIMEOUT - 1));
    leave_c        = wait_expired_c || (state_q == ADC_WAIT && adc_edge_c)
                                    || (state_q == DAC_WAIT && dac_edge_c);
    wait_cnt_d     = (in_wait_c && !leave_c) ? wait_cnt_q + TMO_W'(1) : '0;
    timeout_d      = (wait_expired_c && !((state_q == ADC_WAIT && adc_edge_c) ||
                                          (state_q == DAC_WAIT && dac_edge_c)))
                     ? 1'b1 : (bus.clr_flags ? 1'b0 : timeout_q);
  end

  assign bus.timeout = timeout_q;
`else
  assign wait_expired_c = 1'b0;
  assign bus.timeout    = 1'b0;
`endif

  always_ff @(posedge clock_In or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      filt_cnt_q     <= '0;
      adc_prev_q     <= 1'b0;
      dac_prev_q     <= 1'b0;
      adc_start_q    <= 1'b0;
      sample_load_q  <= 1'b0;
      filt_enable_q  <= 1'b0;
      dac_start_q    <= 1'b0;
      filtro_sel_q   <= 2'b00;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      sample_count_q <= 16'd0;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt_q     <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      filt_cnt_q     <= filt_cnt_d;
      adc_prev_q     <= bus.adc_done;
      dac_prev_q     <= bus.dac_done;
      adc_start_q    <= adc_start_d;
      sample_load_q  <= sample_load_d;
      filt_enable_q  <= filt_enable_d;
      dac_start_q    <= dac_start_d;
      filtro_sel_q   <= filtro_sel_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      sample_count_q <= sample_count_d;
`ifdef SEQ_TIMEOUT_EN
      wait_cnt_q     <= wait_cnt_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign bus.adc_start    = adc_start_q;
  assign bus.sample_load  = sample_load_q;
  assign bus.filt_enable  = filt_enable_q;
  assign bus.dac_start    = dac_start_q;
  assign bus.filtro_sel   = filtro_sel_q;
  assign bus.busy         = busy_q;
  assign bus.overrun      = overrun_q;
  assign bus.sample_count = sample_count_q;

endmodule
